// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU engine producing {HI,LO}
// Optional build macro: DIV_ZERO_FAST_EN (divide-by-zero finishes one cycle after accept).
module muldiv_unit #(
  parameter int unsigned MUL_CYCLES = 1,
  parameter logic [4:0]  ALU_MULT   = 5'b11000,
  parameter logic [4:0]  ALU_MULTU  = 5'b11001,
  parameter logic [4:0]  ALU_DIV    = 5'b11010,
  parameter logic [4:0]  ALU_DIVU   = 5'b11011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alucontrol,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [63:0] result_q, result_d;

  logic        is_mul_op, is_div_op, signed_op, accept, finish;
  logic [31:0] abs_a, abs_b;
  logic [63:0] mul_x, mul_y, product;
  logic [32:0] rem_sh;
  logic        q_bit;
  logic [31:0] rem_nx, quo_nx;

  // Apply the sign correction to an unsigned quotient/remainder pair.
  function automatic logic [63:0] div_fix(input logic [31:0] q, input logic [31:0] r,
                                          input logic nq, input logic nr);
    logic [31:0] qf, rf;
    qf = nq ? (32'd0 - q) : q;
    rf = nr ? (32'd0 - r) : r;
    return {rf, qf};
  endfunction

  assign is_mul_op = (alucontrol == ALU_MULT) || (alucontrol == ALU_MULTU);
  assign is_div_op = (alucontrol == ALU_DIV)  || (alucontrol == ALU_DIVU);
  assign signed_op = (alucontrol == ALU_MULT) || (alucontrol == ALU_DIV);
  assign accept    = (state_q == S_IDLE) && start && (is_mul_op || is_div_op) && !flush;

  assign abs_a = (signed_op && a[31]) ? (32'd0 - a) : a;
  assign abs_b = (signed_op && b[31]) ? (32'd0 - b) : b;

  // Low 64 bits of the product of sign/zero-extended operands is the exact 64-bit product.
  assign mul_x   = {{32{sgn_q & opa_q[31]}}, opa_q};
  assign mul_y   = {{32{sgn_q & opb_q[31]}}, opb_q};
  assign product = mul_x * mul_y;

  // One restoring step: dividend bits shift out of quo_q's top as quotient bits shift in.
  assign rem_sh = {rem_q, quo_q[31]};
  assign q_bit  = rem_sh >= {1'b0, opb_q};
  assign rem_nx = q_bit ? (rem_sh[31:0] - opb_q) : rem_sh[31:0];
  assign quo_nx = {quo_q[30:0], q_bit};

`ifdef DIV_ZERO_FAST_EN
  logic [63:0] fast_res;
  assign fast_res = div_fix(32'hFFFF_FFFF, abs_a, signed_op & (a[31] ^ b[31]), signed_op & a[31]);
`endif

  // FSM next state, stall/done outputs and the result-load strobe
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall = 1'b1;
          if (is_mul_op) begin
            state_d = S_MUL;
`ifdef DIV_ZERO_FAST_EN
          end else if (b == 32'd0) begin
            state_d = S_DONE;
            finish  = 1'b1;
`endif
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        stall = 1'b1;
        if (cnt_q == MUL_LAST) begin
          state_d = S_DONE;
          finish  = 1'b1;
        end
      end
      S_DIV: begin
        stall = 1'b1;
        if (cnt_q == DIV_LAST) begin
          state_d = S_DONE;
          finish  = 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush kills whatever is in flight: no result load, no done pulse.
    if (flush) begin
      state_d = S_IDLE;
      finish  = 1'b0;
      done    = 1'b0;
    end
  end

  // Operand capture, divide iteration and result load
  always_comb begin
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (accept) begin
      cnt_d  = 5'd0;
      sgn_d  = signed_op;
      negq_d = signed_op & (a[31] ^ b[31]);
      negr_d = signed_op & a[31];
      opa_d  = a;
      opb_d  = is_div_op ? abs_b : b;
      quo_d  = abs_a;
      rem_d  = 32'd0;
    end else if (state_q == S_MUL || state_q == S_DIV) begin
      cnt_d = cnt_q + 5'd1;
      if (state_q == S_DIV) begin
        quo_d = quo_nx;
        rem_d = rem_nx;
      end
    end
    if (finish) begin
      case (state_q)
        S_MUL:   result_d = product;
        S_DIV:   result_d = div_fix(quo_nx, rem_nx, negq_q, negr_q);
`ifdef DIV_ZERO_FAST_EN
        S_IDLE:  result_d = fast_res;
`endif
        default: result_d = result_q;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      sgn_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized and directed bench for muldiv_unit (MUL_CYCLES 1 and 3)
module tb_muldiv_unit;

  localparam logic [4:0] MULT  = 5'b11000;
  localparam logic [4:0] MULTU = 5'b11001;
  localparam logic [4:0] DIV   = 5'b11010;
  localparam logic [4:0] DIVU  = 5'b11011;
  localparam logic [4:0] ADD   = 5'b00010;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int DZ_LAT = FAST ? 1 : 33;
  localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [4:0]  alucontrol;
  logic [31:0] a, b;
  logic [1:0]  stall_w, done_w;
  logic [63:0] res_w [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.MUL_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .alucontrol(alucontrol), .start(start), .flush(flush),
    .a(a), .b(b), .stall(stall_w[0]), .done(done_w[0]), .result(res_w[0]));

  muldiv_unit #(.MUL_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .alucontrol(alucontrol), .start(start), .flush(flush),
    .a(a), .b(b), .stall(stall_w[1]), .done(done_w[1]), .result(res_w[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_md(input logic [4:0] op);
    return op == MULT || op == MULTU || op == DIV || op == DIVU;
  endfunction

  // Architectural result of one operation, straight from the arithmetic rules.
  function automatic logic [63:0] ref_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [31:0] q, r, ax;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      MULT:  return 64'(sx * sy);
      MULTU: return {32'd0, x} * {32'd0, y};
      DIVU: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == 0) begin
          ax = x[31] ? -x : x;
          q  = 32'hFFFF_FFFF;
          if (x[31]) q = -q;
          r  = x[31] ? -ax : ax;
          return {r, q};
        end
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = 32'(sx / sy);
        r = 32'(sx % sy);
        return {r, q};
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Behavioural model: per instance, idle / busy-with-N-cycles-left / done.
  bit          mv [2] = '{1'b0, 1'b0};
  int          ms [2];
  int          mleft [2];
  logic [63:0] mpend [2];
  logic [63:0] mres [2];
  bit          acc, e_stall, e_done;

  // Compare every cycle, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mv[k]   = 1'b1;
        ms[k]   = M_IDLE;
        mres[k] = 64'd0;
      end else if (mv[k]) begin
        acc     = start && is_md(alucontrol) && !flush;
        e_stall = (ms[k] == M_IDLE && acc) || ms[k] == M_BUSY;
        e_done  = (ms[k] == M_DONE) && !flush;
        chk($sformatf("stall%0d", k), 64'(stall_w[k]), 64'(e_stall));
        chk($sformatf("done%0d", k), 64'(done_w[k]), 64'(e_done));
        if (e_done || ms[k] == M_IDLE) chk($sformatf("result%0d", k), res_w[k], mres[k]);
        if (flush) ms[k] = M_IDLE;
        else begin
          case (ms[k])
            M_IDLE: if (acc) begin
              mpend[k] = ref_op(alucontrol, a, b);
              if (alucontrol == MULT || alucontrol == MULTU) begin
                ms[k] = M_BUSY; mleft[k] = (k == 0) ? 1 : 3;
              end else if (FAST && b == 32'd0) begin
                ms[k] = M_DONE; mres[k] = mpend[k];
              end else begin
                ms[k] = M_BUSY; mleft[k] = 32;
              end
            end
            M_BUSY: begin
              mleft[k]--;
              if (mleft[k] == 0) begin ms[k] = M_DONE; mres[k] = mpend[k]; end
            end
            default: ms[k] = M_IDLE;
          endcase
        end
      end
    end
  end

  // Issue one op for a single cycle, then scramble inputs and time both done pulses.
  task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input int lat0, input int lat1, input string name);
    int got0, got1;
    alucontrol = op; a = x; b = y; start = 1'b1;
    @(negedge clk);
    chk({name, "_accept_stall"}, 64'(stall_w), 64'(2'b11));
    got0 = (lat0 == 1 && done_w[0]) ? 0 : -1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; alucontrol = 5'($urandom);
    got0 = -1; got1 = -1;
    for (int c = 1; c < 100 && (got0 < 0 || got1 < 0); c++) begin
      @(negedge clk);
      if (done_w[0] && got0 < 0) begin got0 = c; chk({name, "_res0"}, res_w[0], exp); end
      if (done_w[1] && got1 < 0) begin got1 = c; chk({name, "_res1"}, res_w[1], exp); end
      @(posedge clk); #1;
    end
    chk({name, "_lat0"}, 64'(got0), 64'(lat0));
    chk({name, "_lat1"}, 64'(got1), 64'(lat1));
  endtask

  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; flush = 1'b0; alucontrol = 5'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 64'(stall_w), 64'd0);
    chk("reset_done", 64'(done_w), 64'd0);
    chk("reset_result", res_w[0], 64'd0);
    @(posedge clk); #1;

    run_op(DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 33, "divu_100_7");
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 33, "div_m7_2");
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 33, "div_ovf");
    run_op(MULT, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 2, 4, "mult");
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, 2, 4, "multu");
    run_op(DIVU, 32'd1234, 32'd0, {32'd1234, 32'hFFFF_FFFF}, DZ_LAT, DZ_LAT, "divu_by0");
    run_op(DIV, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'h0000_0001}, DZ_LAT, DZ_LAT, "div_m5_by0");

    // Flush in cycle N+10 of a divide.
    alucontrol = DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_stall", 64'(stall_w), 64'd0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      nd += int'(done_w[0]) + int'(done_w[1]);
    end
    chk("flush_no_done", 64'(nd), 64'd0);
    chk("flush_result_kept", res_w[0], {32'hFFFF_FFFB, 32'h0000_0001});
    @(posedge clk); #1;
    run_op(DIVU, 32'd77, 32'd5, {32'd2, 32'd15}, 33, 33, "divu_after_flush");

    // start held through DONE must not launch a second operation.
    alucontrol = DIVU; a = 32'd50; b = 32'd6;
    nd = 0;
    for (int c = 0; c < 45; c++) begin
      start = (c <= 33);
      @(negedge clk);
      nd += int'(done_w[0]);
      @(posedge clk); #1;
    end
    chk("hold_one_done", 64'(nd), 64'd1);
    chk("hold_result", res_w[0], {32'd2, 32'd8});

    // Non-muldiv code with start: no stall, no done.
    alucontrol = ADD; start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      a = $urandom; b = $urandom;
      @(negedge clk);
      chk("add_no_stall", 64'({stall_w, done_w}), 64'd0);
      @(posedge clk); #1;
    end

    // Randomized traffic, checked cycle by cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 599) == 0);
      flush = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 3))
          0: alucontrol = MULT;
          1: alucontrol = MULTU;
          2: alucontrol = DIV;
          default: alucontrol = DIVU;
        endcase
      end else alucontrol = 5'($urandom);
      a = rand_operand();
      b = rand_operand();
      @(posedge clk); #1;
    end
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
